clk_gate_ctrl: RTL and testbench
================================

// Module: clk_gate_ctrl
// PURPOSE
//   Request/acknowledge controller for one gated clock branch built from clkinv/clkbuf cells.
//   Merges NREQ level requests into a single registered clock enable for the branch ICG.
//   Sequences wake-up settle time and idle-hysteresis shutdown.
//   Counts gated-off cycles for power monitoring.
//   Sits in the always-on CLK domain, beside the clock tree root it controls.
// PARAMETERS
//   NREQ         4   number of requesters (1..16)
//   WAKE_CYCLES  2   cycles clk_en is high before acks are given (settle); >=1
//   IDLE_CYCLES  8   cycles with no request before clk_en drops; >=1
//   CNT_W        8   width of wake/idle down-counter; must hold max(WAKE,IDLE)
//   STAT_W       16  width of off-cycle statistics counter
// PORTS
//   CLK       in   1       free-running (ungated) clock, rising edge
//   RN        in   1       async active-low reset
//   req       in   NREQ    level request per requester; held until work done
//   force_on  in   1       keep branch enabled regardless of req (test/debug)
//   clr_stat  in   1       sync clear of off_cnt
//   ack       out  NREQ    grant: branch clock guaranteed running while high
//   clk_en    out  1       registered enable to branch ICG
//   state_o   out  2       current FSM state encoding
//   off_cnt   out  STAT_W  saturating count of cycles spent in OFF
// BEHAVIOUR
//   Reset (RN low, async): state=OFF, clk_en=0, ack=0, counter=0, off_cnt=0.
//   Reset mid-operation drops clk_en and all acks immediately; no drain is performed.
//   All outputs are registered; any_req = |req | force_on.
//   Encoding: OFF=0, WAKE=1, ON=2, DRAIN=3.
//   OFF:   clk_en=0. If any_req, go to WAKE and load counter=WAKE_CYCLES-1.
//   WAKE:  clk_en=1, ack=0. The counter decrements each cycle.
//          When counter==0, go to ON. req deassertion during WAKE does not abort.
//          WAKE always lasts exactly WAKE_CYCLES cycles.
//   ON:    clk_en=1. If any_req is low, go to DRAIN and load counter=IDLE_CYCLES-1.
//   DRAIN: clk_en=1, ack=0.
//          If any_req, return to ON; the ack follows the ON rule below.
//          Else, if counter==0, go to OFF; otherwise decrement.
//          DRAIN therefore lasts exactly IDLE_CYCLES cycles when no request arrives.
//   ack rule: ack_next[i] = req[i] & (next_state==ON).
//          An ack rises in the same cycle state_o becomes ON.
//          An ack falls one cycle after its req falls.
//          force_on alone keeps the FSM in ON but produces no ack.
//   Latency: req sampled in OFF at edge t -> clk_en=1 at t+1, ack=1 at t+1+WAKE_CYCLES.
//          A new req while ON is acked at the next edge.
//   Simultaneous requests: no arbitration; all active requesters share the branch.
//          Each ack is independent of the others.
//   clk_en never toggles more than once per transition.
//          It falls only on the DRAIN->OFF edge and rises only on the OFF->WAKE edge.
//   off_cnt: +1 per cycle with state==OFF; saturates at all-ones with no wrap.
//          clr_stat sets 0 and has priority over the increment.
// TESTING
//   1. Reset, hold req=0 for 5 cycles -> clk_en=0, ack=0, state_o=0, off_cnt=5.
//   2. req[0]=1 in OFF at edge t -> clk_en=1 at t+1, state WAKE for t+1..t+2,
//      ack[0]=1 at t+3; ack[1..3] stay 0.
//   3. Drop req[0] while ON -> ack[0]=0 next edge; DRAIN for 8 cycles; then clk_en=0, OFF.
//   4. Re-request at DRAIN cycle 5 -> back to ON without WAKE; ack at next edge;
//      clk_en never drops.
//   5. req=4'b1011 simultaneously from OFF -> acks 1011 together;
//      drop req[1] -> only ack[1] falls.
//   6. force_on=1, req=0 -> ON with ack=0.
//      Assert RN low mid-ON -> clk_en=0 immediately.
//      Preload off_cnt near all-ones -> saturates; clr_stat -> 0.

Source files
------------

// File: rtl/clk_gate_ctrl.sv
// clk_gate_ctrl: request/ack controller sequencing wake settle, idle drain and off-cycle stats for one gated clock branch
//   CLK      free-running clock          RN        async active-low reset
//   req      level request per requester force_on  hold branch enabled
//   clr_stat sync clear of off_cnt       ack       per-requester grant
//   clk_en   registered ICG enable       state_o   OFF=0 WAKE=1 ON=2 DRAIN=3
//   off_cnt  saturating OFF-cycle count
module clk_gate_ctrl #(
    parameter int NREQ        = 4,
    parameter int WAKE_CYCLES = 2,
    parameter int IDLE_CYCLES = 8,
    parameter int CNT_W       = 8,
    parameter int STAT_W      = 16
) (
    input  logic              CLK,
    input  logic              RN,
    input  logic [NREQ-1:0]   req,
    input  logic              force_on,
    input  logic              clr_stat,
    output logic [NREQ-1:0]   ack,
    output logic              clk_en,
    output logic [1:0]        state_o,
    output logic [STAT_W-1:0] off_cnt
);
    typedef enum logic [1:0] {OFF = 2'd0, WAKE = 2'd1, ON = 2'd2, DRAIN = 2'd3} state_t;
    state_t state_q, state_n;
    logic [CNT_W-1:0] cnt_q, cnt_n;
    logic any_req;
    assign any_req = |req | force_on;
    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        case (state_q)
            OFF: if (any_req) begin
                state_n = WAKE;
                cnt_n   = CNT_W'(WAKE_CYCLES - 1);
            end
            WAKE: if (cnt_q == '0) state_n = ON;
                  else cnt_n = cnt_q - 1'b1;
            ON: if (!any_req) begin
                state_n = DRAIN;
                cnt_n   = CNT_W'(IDLE_CYCLES - 1);
            end
            DRAIN: if (any_req) state_n = ON;
                   else if (cnt_q == '0) state_n = OFF;
                   else cnt_n = cnt_q - 1'b1;
            default: state_n = OFF;
        endcase
    end
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            state_q <= OFF;
            cnt_q   <= '0;
            clk_en  <= 1'b0;
            ack     <= '0;
            off_cnt <= '0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            clk_en  <= state_n != OFF;
            ack     <= req & {NREQ{state_n == ON}};
            off_cnt <= clr_stat ? '0 : (state_q == OFF && !(&off_cnt)) ? off_cnt + 1'b1 : off_cnt;
        end
    end
    assign state_o = state_q;
endmodule

// File: tb/tb_clk_gate_ctrl.sv
// tb_clk_gate_ctrl: directed + randomized check of clk_gate_ctrl against a cycle-age reference model
module tb_clk_gate_ctrl;
    localparam int WAKE = 2;
    localparam int IDLE = 8;
    localparam int SW   = 5;
    localparam int OMAX = (1 << SW) - 1;
    logic          CLK = 1'b0;
    logic          RN = 1'b0;
    logic [3:0]    req = '0;
    logic          force_on = 1'b0;
    logic          clr_stat = 1'b0;
    logic [3:0]    ack;
    logic          clk_en;
    logic [1:0]    state_o;
    logic [SW-1:0] off_cnt;
    int checks = 0;
    int failures = 0;
    bit m_en;
    int m_age, m_idle, m_off;
    logic [3:0] m_ack;
    clk_gate_ctrl #(.NREQ(4), .WAKE_CYCLES(WAKE), .IDLE_CYCLES(IDLE), .CNT_W(8), .STAT_W(SW)) dut (
        .CLK(CLK), .RN(RN), .req(req), .force_on(force_on), .clr_stat(clr_stat),
        .ack(ack), .clk_en(clk_en), .state_o(state_o), .off_cnt(off_cnt)
    );
    always #5 CLK = ~CLK;
    function automatic int m_state();
        return !m_en ? 0 : (m_age <= WAKE) ? 1 : (m_idle == 0) ? 2 : 3;
    endfunction
    task automatic m_reset();
        m_en = 0; m_age = 0; m_idle = 0; m_off = 0; m_ack = '0;
    endtask
    // m_age counts enabled cycles (1..WAKE is settle); m_idle counts consecutive idle cycles once up
    task automatic m_edge(input logic [3:0] r, input logic f, input logic c);
        bit any;
        any = (|r) | f;
        if (c) m_off = 0;
        else if (!m_en && m_off < OMAX) m_off++;
        if (!m_en) begin
            if (any) begin m_en = 1; m_age = 1; m_idle = 0; end
        end else if (m_age <= WAKE) m_age++;
        else if (m_idle == 0) begin
            if (!any) m_idle = 1;
        end else if (any) m_idle = 0;
        else if (m_idle == IDLE) m_en = 0;
        else m_idle++;
        m_ack = (m_state() == 2) ? r : 4'b0;
    endtask
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic chk_all();
        chk("clk_en", 32'(clk_en), 32'(m_en));
        chk("state_o", 32'(state_o), 32'(m_state()));
        chk("ack", 32'(ack), 32'(m_ack));
        chk("off_cnt", 32'(off_cnt), 32'(m_off));
    endtask
    task automatic tick(input logic [3:0] r, input logic f, input logic c);
        req = r; force_on = f; clr_stat = c;
        @(posedge CLK);
        m_edge(r, f, c);
        #1;
        chk_all();
    endtask
    initial begin
        logic [3:0] rr;
        logic ff;
        m_reset();
        #12 RN = 1'b1;
        chk_all();
        // idle after reset
        repeat (5) tick(4'b0000, 1'b0, 1'b0);
        chk("t1_off_cnt", 32'(off_cnt), 32'd5);
        chk("t1_state", 32'(state_o), 32'd0);
        // wake latency and single ack
        tick(4'b0001, 1'b0, 1'b0);
        chk("t2_en", 32'(clk_en), 32'd1);
        chk("t2_wake", 32'(state_o), 32'd1);
        tick(4'b0001, 1'b0, 1'b0);
        chk("t2_ack_low", 32'(ack), 32'd0);
        tick(4'b0001, 1'b0, 1'b0);
        chk("t2_ack", 32'(ack), 32'b0001);
        // drain to off
        tick(4'b0000, 1'b0, 1'b0);
        chk("t3_ack_drop", 32'(ack), 32'd0);
        repeat (7) tick(4'b0000, 1'b0, 1'b0);
        chk("t3_still_drain", 32'(state_o), 32'd3);
        tick(4'b0000, 1'b0, 1'b0);
        chk("t3_off_en", 32'(clk_en), 32'd0);
        // re-request during drain returns to ON directly
        repeat (3) tick(4'b0001, 1'b0, 1'b0);
        repeat (5) tick(4'b0000, 1'b0, 1'b0);
        tick(4'b0001, 1'b0, 1'b0);
        chk("t4_on", 32'(state_o), 32'd2);
        chk("t4_ack", 32'(ack), 32'b0001);
        // shared requests
        repeat (10) tick(4'b0000, 1'b0, 1'b0);
        repeat (3) tick(4'b1011, 1'b0, 1'b0);
        chk("t5_ack", 32'(ack), 32'b1011);
        tick(4'b1001, 1'b0, 1'b0);
        chk("t5_ack_drop1", 32'(ack), 32'b1001);
        // force_on, then async reset mid-ON
        repeat (10) tick(4'b0000, 1'b0, 1'b0);
        repeat (4) tick(4'b0000, 1'b1, 1'b0);
        chk("t6_force_ack", 32'(ack), 32'd0);
        #2 RN = 1'b0;
        #1;
        m_reset();
        chk("t6_rst_en", 32'(clk_en), 32'd0);
        chk_all();
        #2 RN = 1'b1;
        // saturation and clear
        repeat (OMAX + 4) tick(4'b0000, 1'b0, 1'b0);
        chk("t6_sat", 32'(off_cnt), 32'(OMAX));
        tick(4'b0000, 1'b0, 1'b1);
        chk("t6_clr", 32'(off_cnt), 32'd0);
        // randomized traffic with sticky requests
        rr = '0;
        ff = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) rr = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 15) == 0) ff = ~ff;
            if ($urandom_range(0, 7) == 0 && rr != 0) rr = '0;
            tick(rr, ff, $urandom_range(0, 63) == 0);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
